// File: rtl/inv_shift_sub_bytes.sv
// ---------------------------------------------------------------------------
// inv_shift_sub_bytes
//
// Byte-serial AES decryption stage: InvShiftRows followed by InvSubBytes on
// one 128-bit state. The row rotation is applied while the state is latched.
// The inverse S-box is then applied LANES bytes per cycle to the working
// register.
//
// Byte k of a state is bits [127-8k -: 8] and sits at row k%4, column k/4.
//
// Parameters
//   LANES      bytes substituted per cycle (1, 2, 4, 8 or 16)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   in_state is presented
//   in_ready   block can accept a state this cycle (high only in IDLE)
//   in_state   input state
//   out_valid  out_state holds a result
//   out_ready  downstream accepts out_state
//   out_state  InvSubBytes(InvShiftRows(in_state)); holds the last result
//   busy       high while a state is being processed or awaiting hand-off
// ---------------------------------------------------------------------------
module inv_shift_sub_bytes #(
    parameter int unsigned LANES = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("inv_shift_sub_bytes: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic [3:0]   r_idx;
    logic [127:0] r_work;
    logic [127:0] r_out;
    logic         r_in_ready;
    logic         r_out_valid;
    logic         r_busy;

    logic [7:0]   w_bytes      [16];
    logic [7:0]   w_bytes_next [16];
    logic [127:0] w_work_sub;
    logic [127:0] w_in_shifted;
    logic         w_accept;
    logic         w_last;

    // FIPS-197 inverse S-box.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        inv_sbox = '0;
        case (b)
            8'h00: inv_sbox = 8'h52; 8'h01: inv_sbox = 8'h09; 8'h02: inv_sbox = 8'h6a; 8'h03: inv_sbox = 8'hd5;
            8'h04: inv_sbox = 8'h30; 8'h05: inv_sbox = 8'h36; 8'h06: inv_sbox = 8'ha5; 8'h07: inv_sbox = 8'h38;
            8'h08: inv_sbox = 8'hbf; 8'h09: inv_sbox = 8'h40; 8'h0a: inv_sbox = 8'ha3; 8'h0b: inv_sbox = 8'h9e;
            8'h0c: inv_sbox = 8'h81; 8'h0d: inv_sbox = 8'hf3; 8'h0e: inv_sbox = 8'hd7; 8'h0f: inv_sbox = 8'hfb;
            8'h10: inv_sbox = 8'h7c; 8'h11: inv_sbox = 8'he3; 8'h12: inv_sbox = 8'h39; 8'h13: inv_sbox = 8'h82;
            8'h14: inv_sbox = 8'h9b; 8'h15: inv_sbox = 8'h2f; 8'h16: inv_sbox = 8'hff; 8'h17: inv_sbox = 8'h87;
            8'h18: inv_sbox = 8'h34; 8'h19: inv_sbox = 8'h8e; 8'h1a: inv_sbox = 8'h43; 8'h1b: inv_sbox = 8'h44;
            8'h1c: inv_sbox = 8'hc4; 8'h1d: inv_sbox = 8'hde; 8'h1e: inv_sbox = 8'he9; 8'h1f: inv_sbox = 8'hcb;
            8'h20: inv_sbox = 8'h54; 8'h21: inv_sbox = 8'h7b; 8'h22: inv_sbox = 8'h94; 8'h23: inv_sbox = 8'h32;
            8'h24: inv_sbox = 8'ha6; 8'h25: inv_sbox = 8'hc2; 8'h26: inv_sbox = 8'h23; 8'h27: inv_sbox = 8'h3d;
            8'h28: inv_sbox = 8'hee; 8'h29: inv_sbox = 8'h4c; 8'h2a: inv_sbox = 8'h95; 8'h2b: inv_sbox = 8'h0b;
            8'h2c: inv_sbox = 8'h42; 8'h2d: inv_sbox = 8'hfa; 8'h2e: inv_sbox = 8'hc3; 8'h2f: inv_sbox = 8'h4e;
            8'h30: inv_sbox = 8'h08; 8'h31: inv_sbox = 8'h2e; 8'h32: inv_sbox = 8'ha1; 8'h33: inv_sbox = 8'h66;
            8'h34: inv_sbox = 8'h28; 8'h35: inv_sbox = 8'hd9; 8'h36: inv_sbox = 8'h24; 8'h37: inv_sbox = 8'hb2;
            8'h38: inv_sbox = 8'h76; 8'h39: inv_sbox = 8'h5b; 8'h3a: inv_sbox = 8'ha2; 8'h3b: inv_sbox = 8'h49;
            8'h3c: inv_sbox = 8'h6d; 8'h3d: inv_sbox = 8'h8b; 8'h3e: inv_sbox = 8'hd1; 8'h3f: inv_sbox = 8'h25;
            8'h40: inv_sbox = 8'h72; 8'h41: inv_sbox = 8'hf8; 8'h42: inv_sbox = 8'hf6; 8'h43: inv_sbox = 8'h64;
            8'h44: inv_sbox = 8'h86; 8'h45: inv_sbox = 8'h68; 8'h46: inv_sbox = 8'h98; 8'h47: inv_sbox = 8'h16;
            8'h48: inv_sbox = 8'hd4; 8'h49: inv_sbox = 8'ha4; 8'h4a: inv_sbox = 8'h5c; 8'h4b: inv_sbox = 8'hcc;
            8'h4c: inv_sbox = 8'h5d; 8'h4d: inv_sbox = 8'h65; 8'h4e: inv_sbox = 8'hb6; 8'h4f: inv_sbox = 8'h92;
            8'h50: inv_sbox = 8'h6c; 8'h51: inv_sbox = 8'h70; 8'h52: inv_sbox = 8'h48; 8'h53: inv_sbox = 8'h50;
            8'h54: inv_sbox = 8'hfd; 8'h55: inv_sbox = 8'hed; 8'h56: inv_sbox = 8'hb9; 8'h57: inv_sbox = 8'hda;
            8'h58: inv_sbox = 8'h5e; 8'h59: inv_sbox = 8'h15; 8'h5a: inv_sbox = 8'h46; 8'h5b: inv_sbox = 8'h57;
            8'h5c: inv_sbox = 8'ha7; 8'h5d: inv_sbox = 8'h8d; 8'h5e: inv_sbox = 8'h9d; 8'h5f: inv_sbox = 8'h84;
            8'h60: inv_sbox = 8'h90; 8'h61: inv_sbox = 8'hd8; 8'h62: inv_sbox = 8'hab; 8'h63: inv_sbox = 8'h00;
            8'h64: inv_sbox = 8'h8c; 8'h65: inv_sbox = 8'hbc; 8'h66: inv_sbox = 8'hd3; 8'h67: inv_sbox = 8'h0a;
            8'h68: inv_sbox = 8'hf7; 8'h69: inv_sbox = 8'he4; 8'h6a: inv_sbox = 8'h58; 8'h6b: inv_sbox = 8'h05;
            8'h6c: inv_sbox = 8'hb8; 8'h6d: inv_sbox = 8'hb3; 8'h6e: inv_sbox = 8'h45; 8'h6f: inv_sbox = 8'h06;
            8'h70: inv_sbox = 8'hd0; 8'h71: inv_sbox = 8'h2c; 8'h72: inv_sbox = 8'h1e; 8'h73: inv_sbox = 8'h8f;
            8'h74: inv_sbox = 8'hca; 8'h75: inv_sbox = 8'h3f; 8'h76: inv_sbox = 8'h0f; 8'h77: inv_sbox = 8'h02;
            8'h78: inv_sbox = 8'hc1; 8'h79: inv_sbox = 8'haf; 8'h7a: inv_sbox = 8'hbd; 8'h7b: inv_sbox = 8'h03;
            8'h7c: inv_sbox = 8'h01; 8'h7d: inv_sbox = 8'h13; 8'h7e: inv_sbox = 8'h8a; 8'h7f: inv_sbox = 8'h6b;
            8'h80: inv_sbox = 8'h3a; 8'h81: inv_sbox = 8'h91; 8'h82: inv_sbox = 8'h11; 8'h83: inv_sbox = 8'h41;
            8'h84: inv_sbox = 8'h4f; 8'h85: inv_sbox = 8'h67; 8'h86: inv_sbox = 8'hdc; 8'h87: inv_sbox = 8'hea;
            8'h88: inv_sbox = 8'h97; 8'h89: inv_sbox = 8'hf2; 8'h8a: inv_sbox = 8'hcf; 8'h8b: inv_sbox = 8'hce;
            8'h8c: inv_sbox = 8'hf0; 8'h8d: inv_sbox = 8'hb4; 8'h8e: inv_sbox = 8'he6; 8'h8f: inv_sbox = 8'h73;
            8'h90: inv_sbox = 8'h96; 8'h91: inv_sbox = 8'hac; 8'h92: inv_sbox = 8'h74; 8'h93: inv_sbox = 8'h22;
            8'h94: inv_sbox = 8'he7; 8'h95: inv_sbox = 8'had; 8'h96: inv_sbox = 8'h35; 8'h97: inv_sbox = 8'h85;
            8'h98: inv_sbox = 8'he2; 8'h99: inv_sbox = 8'hf9; 8'h9a: inv_sbox = 8'h37; 8'h9b: inv_sbox = 8'he8;
            8'h9c: inv_sbox = 8'h1c; 8'h9d: inv_sbox = 8'h75; 8'h9e: inv_sbox = 8'hdf; 8'h9f: inv_sbox = 8'h6e;
            8'ha0: inv_sbox = 8'h47; 8'ha1: inv_sbox = 8'hf1; 8'ha2: inv_sbox = 8'h1a; 8'ha3: inv_sbox = 8'h71;
            8'ha4: inv_sbox = 8'h1d; 8'ha5: inv_sbox = 8'h29; 8'ha6: inv_sbox = 8'hc5; 8'ha7: inv_sbox = 8'h89;
            8'ha8: inv_sbox = 8'h6f; 8'ha9: inv_sbox = 8'hb7; 8'haa: inv_sbox = 8'h62; 8'hab: inv_sbox = 8'h0e;
            8'hac: inv_sbox = 8'haa; 8'had: inv_sbox = 8'h18; 8'hae: inv_sbox = 8'hbe; 8'haf: inv_sbox = 8'h1b;
            8'hb0: inv_sbox = 8'hfc; 8'hb1: inv_sbox = 8'h56; 8'hb2: inv_sbox = 8'h3e; 8'hb3: inv_sbox = 8'h4b;
            8'hb4: inv_sbox = 8'hc6; 8'hb5: inv_sbox = 8'hd2; 8'hb6: inv_sbox = 8'h79; 8'hb7: inv_sbox = 8'h20;
            8'hb8: inv_sbox = 8'h9a; 8'hb9: inv_sbox = 8'hdb; 8'hba: inv_sbox = 8'hc0; 8'hbb: inv_sbox = 8'hfe;
            8'hbc: inv_sbox = 8'h78; 8'hbd: inv_sbox = 8'hcd; 8'hbe: inv_sbox = 8'h5a; 8'hbf: inv_sbox = 8'hf4;
            8'hc0: inv_sbox = 8'h1f; 8'hc1: inv_sbox = 8'hdd; 8'hc2: inv_sbox = 8'ha8; 8'hc3: inv_sbox = 8'h33;
            8'hc4: inv_sbox = 8'h88; 8'hc5: inv_sbox = 8'h07; 8'hc6: inv_sbox = 8'hc7; 8'hc7: inv_sbox = 8'h31;
            8'hc8: inv_sbox = 8'hb1; 8'hc9: inv_sbox = 8'h12; 8'hca: inv_sbox = 8'h10; 8'hcb: inv_sbox = 8'h59;
            8'hcc: inv_sbox = 8'h27; 8'hcd: inv_sbox = 8'h80; 8'hce: inv_sbox = 8'hec; 8'hcf: inv_sbox = 8'h5f;
            8'hd0: inv_sbox = 8'h60; 8'hd1: inv_sbox = 8'h51; 8'hd2: inv_sbox = 8'h7f; 8'hd3: inv_sbox = 8'ha9;
            8'hd4: inv_sbox = 8'h19; 8'hd5: inv_sbox = 8'hb5; 8'hd6: inv_sbox = 8'h4a; 8'hd7: inv_sbox = 8'h0d;
            8'hd8: inv_sbox = 8'h2d; 8'hd9: inv_sbox = 8'he5; 8'hda: inv_sbox = 8'h7a; 8'hdb: inv_sbox = 8'h9f;
            8'hdc: inv_sbox = 8'h93; 8'hdd: inv_sbox = 8'hc9; 8'hde: inv_sbox = 8'h9c; 8'hdf: inv_sbox = 8'hef;
            8'he0: inv_sbox = 8'ha0; 8'he1: inv_sbox = 8'he0; 8'he2: inv_sbox = 8'h3b; 8'he3: inv_sbox = 8'h4d;
            8'he4: inv_sbox = 8'hae; 8'he5: inv_sbox = 8'h2a; 8'he6: inv_sbox = 8'hf5; 8'he7: inv_sbox = 8'hb0;
            8'he8: inv_sbox = 8'hc8; 8'he9: inv_sbox = 8'heb; 8'hea: inv_sbox = 8'hbb; 8'heb: inv_sbox = 8'h3c;
            8'hec: inv_sbox = 8'h83; 8'hed: inv_sbox = 8'h53; 8'hee: inv_sbox = 8'h99; 8'hef: inv_sbox = 8'h61;
            8'hf0: inv_sbox = 8'h17; 8'hf1: inv_sbox = 8'h2b; 8'hf2: inv_sbox = 8'h04; 8'hf3: inv_sbox = 8'h7e;
            8'hf4: inv_sbox = 8'hba; 8'hf5: inv_sbox = 8'h77; 8'hf6: inv_sbox = 8'hd6; 8'hf7: inv_sbox = 8'h26;
            8'hf8: inv_sbox = 8'he1; 8'hf9: inv_sbox = 8'h69; 8'hfa: inv_sbox = 8'h14; 8'hfb: inv_sbox = 8'h63;
            8'hfc: inv_sbox = 8'h55; 8'hfd: inv_sbox = 8'h21; 8'hfe: inv_sbox = 8'h0c; 8'hff: inv_sbox = 8'h7d;
        endcase
    endfunction

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_state = r_out;
    assign busy      = r_busy;

    assign w_accept = in_valid && r_in_ready;

    // idx always advances in multiples of LANES from 0, so the window that
    // covers byte 15 is exactly the one ending at 16.
    assign w_last = (({1'b0, r_idx} + 5'(LANES)) == 5'd16);

    // InvShiftRows: row r, column c takes input row r, column (c - r) mod 4.
    always_comb begin
        w_in_shifted = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                w_in_shifted[127 - 8*(4*c + r) -: 8] =
                    in_state[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < 16; k++) begin
            w_bytes[k] = r_work[127 - 8*k -: 8];
        end
    end

    // Only LANES lookups are built; the window position selects which bytes
    // are routed through them.
    always_comb begin
        for (int unsigned k = 0; k < 16; k++) begin
            w_bytes_next[k] = w_bytes[k];
        end
        for (int unsigned l = 0; l < LANES; l++) begin
            w_bytes_next[r_idx + 4'(l)] = inv_sbox(w_bytes[r_idx + 4'(l)]);
        end
    end

    always_comb begin
        w_work_sub = '0;
        for (int unsigned k = 0; k < 16; k++) begin
            w_work_sub[127 - 8*k -: 8] = w_bytes_next[k];
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept)                  w_state_next = S_BUSY;
            S_BUSY: if (w_last)                    w_state_next = S_DONE;
            S_DONE: if (r_out_valid && out_ready)  w_state_next = S_IDLE;
            default:                               w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_work      <= '0;
            r_out       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            // Status flags are registered decodes of the next state.
            r_in_ready  <= (w_state_next == S_IDLE);
            r_out_valid <= (w_state_next == S_DONE);
            r_busy      <= (w_state_next != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_work <= w_in_shifted;
                        r_idx  <= '0;
                    end
                end
                S_BUSY: begin
                    r_work <= w_work_sub;
                    r_idx  <= r_idx + 4'(LANES);
                    if (w_last) begin
                        r_out <= w_work_sub;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_shift_sub_bytes.sv
// ---------------------------------------------------------------------------
// tb_inv_shift_sub_bytes
//
// Five instances (LANES = 1, 2, 4, 8, 16) share clock, reset, in_state and
// out_ready; each has its own in_valid. Most steps drive only the LANES = 1
// instance. Expected results come from a reference model that derives the
// inverse S-box from GF(2^8) arithmetic and applies the row rotation by
// index arithmetic.
// ---------------------------------------------------------------------------
module tb_inv_shift_sub_bytes;

    localparam logic [127:0] V1 = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    localparam logic [127:0] K1 = 128'hbd6e7c3df2b5779e0b61216e8b10b689;

    logic         clk;
    logic         reset;
    logic [4:0]   in_valid;
    logic [4:0]   in_ready;
    logic [127:0] in_state;
    logic [4:0]   out_valid;
    logic         out_ready;
    logic [127:0] out_state [5];
    logic [4:0]   busy;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [7:0]   ref_isb [256];
    logic [127:0] exp_q [$];

    for (genvar g = 0; g < 5; g++) begin : g_dut
        inv_shift_sub_bytes #(.LANES(1 << g)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_state  (in_state),
            .out_valid (out_valid[g]),
            .out_ready (out_ready),
            .out_state (out_state[g]),
            .busy      (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = '0;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic void build_ref_table();
        logic [7:0] y;
        logic [7:0] z;
        for (int x = 0; x < 256; x++) begin
            // inverse affine map, then multiplicative inverse (0 maps to 0)
            y = rotl8(8'(x), 1) ^ rotl8(8'(x), 3) ^ rotl8(8'(x), 6) ^ 8'h05;
            z = '0;
            if (y != 8'h00) begin
                for (int c = 1; c < 256; c++) begin
                    if (gmul(y, 8'(c)) == 8'h01) z = 8'(c);
                end
            end
            ref_isb[x] = z;
        end
    endfunction

    function automatic logic [127:0] ref_model(input logic [127:0] s);
        logic [7:0]   b [16];
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++) b[k] = s[127 - 8*k -: 8];
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127 - 8*(4*c + r) -: 8] = ref_isb[b[4*((c - r + 4) % 4) + r]];
            end
        end
        return o;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge; returns #1 after the accepting edge.
    task automatic send0(input logic [127:0] d);
        bit got;
        got = 1'b0;
        in_state    = d;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (in_ready[0]) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (got) begin
            @(posedge clk); #1;
        end
        in_valid[0] = 1'b0;
        if (!got) check("accept_timeout", 128'd0, 128'd1);
    endtask

    task automatic wait_out0(input int exp_lat, input logic [127:0] exp, input string tag);
        int lat;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (out_valid[0]) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
        check({tag, "_data"}, out_state[0], exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] d;
        logic [127:0] d2;
        logic [127:0] exp_d;
        int           lat [5];
        logic [127:0] got [5];
        bit           done;
        int           n_out;

        build_ref_table();
        reset     = 1'b1;
        in_valid  = '0;
        in_state  = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  128'(in_ready),  128'h1f);
        check("rst_out_valid", 128'(out_valid), 128'h0);
        check("rst_busy",      128'(busy),      128'h0);
        check("rst_out_state", out_state[0],    128'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: known-answer vector, LANES = 1
        out_ready = 1'b1;
        send0(V1);
        check("s1_busy_after_accept",  128'(busy[0]),     128'd1);
        check("s1_ready_after_accept", 128'(in_ready[0]), 128'd0);
        wait_out0(16, K1, "s1");
        @(posedge clk); #1;
        check("s1_valid_cleared", 128'(out_valid[0]), 128'd0);
        check("s1_ready_again",   128'(in_ready[0]),  128'd1);
        check("s1_result_held",   out_state[0],       K1);

        // 2: same vector into every LANES variant at once
        check("s2_all_ready", 128'(in_ready), 128'h1f);
        for (int g = 0; g < 5; g++) begin
            lat[g] = 0;
            got[g] = '0;
        end
        in_state = V1;
        in_valid = 5'h1f;
        @(posedge clk); #1;
        in_valid = '0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            for (int g = 0; g < 5; g++) begin
                if (out_valid[g] && lat[g] == 0) begin
                    lat[g] = k;
                    got[g] = out_state[g];
                end
            end
        end
        for (int g = 0; g < 5; g++) begin
            check($sformatf("s2_lanes%0d_latency", 1 << g), 128'(lat[g]), 128'(16 >> g));
            check($sformatf("s2_lanes%0d_data", 1 << g), got[g], K1);
        end

        // 3: boundary byte values
        send0(128'h0);
        wait_out0(16, 128'h52525252525252525252525252525252, "s3_zero");
        @(posedge clk); #1;
        send0({16{8'h63}});
        wait_out0(16, 128'h0, "s3_all63");
        @(posedge clk); #1;

        // 4: back-pressure, with a competing in_valid during DONE
        out_ready = 1'b0;
        d     = {$urandom, $urandom, $urandom, $urandom};
        exp_d = ref_model(d);
        send0(d);
        wait_out0(16, exp_d, "s4");
        d2          = {$urandom, $urandom, $urandom, $urandom};
        in_state    = d2;
        in_valid[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("s4_hold_valid", 128'(out_valid[0]), 128'd1);
            check("s4_hold_data",  out_state[0],       exp_d);
            check("s4_hold_ready", 128'(in_ready[0]),  128'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("s4_released_valid", 128'(out_valid[0]), 128'd0);
        check("s4_released_ready", 128'(in_ready[0]),  128'd1);
        check("s4_not_accepted",   128'(busy[0]),      128'd0);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        check("s4_next_accepted", 128'(busy[0]), 128'd1);
        wait_out0(16, ref_model(d2), "s4_next");
        @(posedge clk); #1;

        // 5: reset in the middle of a substitution pass (idx = 8)
        send0(V1);
        repeat (8) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("s5_rst_out_valid", 128'(out_valid[0]), 128'd0);
        check("s5_rst_in_ready",  128'(in_ready[0]),  128'd1);
        check("s5_rst_busy",      128'(busy[0]),      128'd0);
        check("s5_rst_out_state", out_state[0],       128'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        d = {$urandom, $urandom, $urandom, $urandom};
        send0(d);
        wait_out0(16, ref_model(d), "s5_after");
        @(posedge clk); #1;

        // 6: 20 random states with random output stalls, in-order scoreboard
        n_out = 0;
        for (int i = 0; i < 20; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            exp_q.push_back(ref_model(d));
            send0(d);
            done = 1'b0;
            for (int c = 0; c < 120; c++) begin
                @(posedge clk); #1;
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid[0] && out_ready) begin
                    check($sformatf("s6_result%0d", i), out_state[0], exp_q.pop_front());
                    n_out++;
                    @(posedge clk); #1;
                    check($sformatf("s6_single%0d", i), 128'(out_valid[0]), 128'd0);
                    done = 1'b1;
                    break;
                end
            end
            if (!done) check($sformatf("s6_timeout%0d", i), 128'd0, 128'd1);
        end
        check("s6_count",     128'(n_out),        128'd20);
        check("s6_queue_empty", 128'(exp_q.size()), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
